adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one 32-bit adder between two requesters using valid/ready handshakes and round-robin arbitration. It sits between the datapath units that need an addition (requester 0: PC/next-address logic; requester 1: load/store address generation) and the single shared adder. The result, carry and signed-overflow flag are registered and returned on one response channel, tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 presents operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid  input  1  requester 1 presents operands
- req1_ready  output  1  requester 1 operands accepted this cycle
- req1_a, req1_b  input  WIDTH  requester 1 operands
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_id  output  1  requester that owns the response (0 or 1)
- rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH
- rsp_carry  output  1  unsigned carry-out, bit WIDTH of the sum
- rsp_ovf  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]

## Operation
- Two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). The output register is the only buffer.
- can_accept = !rsp_valid | rsp_ready.
- Grant is combinational from the valids and the last_grant register:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = grantN & can_accept. At most one ready is high in any cycle. A ready never goes high for a requester whose valid is low.
- Transfer (reqN_valid & reqN_ready) at an edge:
  - Operands of requester N go to the adder.
  - rsp_sum, rsp_carry and rsp_ovf are loaded; rsp_id<=N; rsp_valid<=1.
  - last_grant<=N.
- Transitions:
  - rsp_ready & rsp_valid with no transfer: rsp_valid<=0; data outputs hold their values.
  - EMPTY->FULL on a transfer.
  - FULL->FULL on a transfer while rsp_ready=1 (back-to-back operation).
  - FULL->EMPTY on rsp_ready with no transfer.
  - FULL with rsp_ready=0: all outputs hold; both readys are 0.
- Arithmetic:
  - Sum is computed at WIDTH+1 bits. No saturation.
  - Wrap-around of the sum is reported only through rsp_carry.
- Requesters must keep valid and operands stable until ready. The block does not check this.
- Reset (asynchronous, any time, including while FULL):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, last_grant=1, so requester 0 wins the first contention.
  - An in-flight response is discarded.
  - Readys are low while rst_n=0.

## Timing
- Latency is 1 cycle: a transfer at edge N gives rsp_valid=1 with valid data after edge N.
- Throughput is 1 result per cycle while rsp_ready=1.
- Under continuous contention with rsp_ready=1, grants alternate 0,1,0,1…. Each requester waits at most 1 cycle.
- reqN_ready depends combinationally on req0_valid, req1_valid, rsp_valid, rsp_ready and last_grant. There is no combinational path from operands to any output.
- rsp_* outputs come directly from registers.
- rst_n deassertion is synchronised externally. The block requires only that deassertion meets recovery time relative to clk.

## Test plan
- Reset mid-FULL: a transfer of 5+7, then rst_n low with rsp_ready=0 → outputs go to 0 immediately, without a clock edge; after release, the first contention grants req0.
- Single request: req0 a=0x00000005, b=0x00000007, rsp_ready=1 → req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x0000000C, carry=0, ovf=0.
- Wrap and overflow:
  - 0xFFFFFFFF+0x00000001 → sum=0x00000000, carry=1, ovf=0.
  - 0x7FFFFFFF+0x00000001 → sum=0x80000000, carry=0, ovf=1.
- Contention: both valid for 4 cycles with rsp_ready=1 → rsp_id sequence 0,1,0,1 after reset; each reqN_ready pulses on alternate cycles.
- Backpressure: rsp_ready=0 for 3 cycles while FULL with both requesters valid → both readys stay 0 and rsp_* hold; when rsp_ready rises, a new transfer is accepted in the same cycle.
- Idle drain: one transfer, then no valids, with rsp_ready=1 → rsp_valid is high for exactly 1 cycle; rsp_sum holds its value after rsp_valid falls.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two valid/ready requesters.
// The registered result, carry and signed overflow return on a single response channel tagged with the winner.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_ovf
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             grant0, grant1;
    logic             can_accept;
    logic             xfer0, xfer1, xfer;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   full_sum;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;
    assign xfer  = xfer0 | xfer1;

    assign op_a     = xfer1 ? req1_a : req0_a;
    assign op_b     = xfer1 ? req1_b : req0_b;
    assign full_sum = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;
        if (xfer) begin
            state_d      = FULL;
            last_grant_d = xfer1;
            id_d         = xfer1;
            sum_d        = full_sum[WIDTH-1:0];
            carry_d      = full_sum[WIDTH];
            ovf_d        = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (full_sum[WIDTH-1] != op_a[WIDTH-1]);
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Readys are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        rsp_valid  = (state_q == FULL);
        can_accept = !rsp_valid || rsp_ready;
        req0_ready = rst_n && grant0 && can_accept;
        req1_ready = rst_n && grant1 && can_accept;
        rsp_id     = id_q;
        rsp_sum    = sum_q;
        rsp_carry  = carry_q;
        rsp_ovf    = ovf_q;
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed spec scenarios plus randomized traffic
// compared against a transaction-level model built from plain arithmetic.
module tb_adder_arbiter;

    localparam int W = 32;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_ovf;
    logic [W-1:0] rsp_sum;

    int errors = 0;
    int checks = 0;

    // Model of the response register and round-robin history
    bit           mValid, mId, mCarry, mOvf, mLast;
    logic [W-1:0] mSum;
    bit           exp0, exp1, lastAcc0, lastAcc1;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
    );

    function automatic void resetModel();
        mValid = 0; mId = 0; mSum = '0; mCarry = 0; mOvf = 0; mLast = 1;
    endfunction

    function automatic void loadModel(input logic [W-1:0] a, input logic [W-1:0] b, input bit id);
        longint u, s;
        u = longint'(a) + longint'(b);
        s = longint'($signed(a)) + longint'($signed(b));
        mSum   = u[W-1:0];
        mCarry = (u >= 64'h1_0000_0000);
        mOvf   = (s > SMAX) || (s < SMIN);
        mId    = id;
        mValid = 1;
        mLast  = id;
    endfunction

    function automatic logic [35:0] modelRsp();
        return {mValid, mId, mCarry, mOvf, mSum};
    endfunction

    function automatic void predict();
        int w;
        bit can;
        can = !mValid || (rsp_ready === 1'b1);
        w = -1;
        if (req0_valid && req1_valid) w = mLast ? 0 : 1;
        else if (req0_valid)          w = 0;
        else if (req1_valid)          w = 1;
        exp0 = (rst_n === 1'b1) && can && (w == 0);
        exp1 = (rst_n === 1'b1) && can && (w == 1);
    endfunction

    // Advance one clock edge, applying the predicted transfer to the model.
    task automatic clockModel();
        logic [W-1:0] a0, b0, a1, b1;
        bit rr;
        predict();
        lastAcc0 = exp0; lastAcc1 = exp1;
        a0 = req0_a; b0 = req0_b; a1 = req1_a; b1 = req1_b; rr = rsp_ready;
        @(posedge clk);
        if (rst_n === 1'b1) begin
            if (exp0)      loadModel(a0, b0, 1'b0);
            else if (exp1) loadModel(a1, b1, 1'b1);
            else if (rr)   mValid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        resetModel();
        #3;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== 36'h0) begin
            errors++; $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_hold: got %b expected 000", {req0_ready, req1_ready, rsp_valid});
        end
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req0_valid = 1; req0_a = 32'h5; req0_b = 32'h7; rsp_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        clockModel();
        req0_valid = 0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== {4'b1000, 32'h0000_000C}) begin
            errors++; $display("[TB] FAIL single_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, {4'b1000, 32'h0000_000C});
        end
    endtask

    task automatic test_wrap();
        req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; rsp_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL wrap_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        clockModel();
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== {4'b1110, 32'h0}) begin
            errors++; $display("[TB] FAIL wrap_carry: got %h expected %h", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, {4'b1110, 32'h0});
        end
        req1_a = 32'h7FFF_FFFF; req1_b = 32'h1;
        clockModel();
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== {4'b1101, 32'h8000_0000}) begin
            errors++; $display("[TB] FAIL wrap_ovf: got %h expected %h", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, {4'b1101, 32'h8000_0000});
        end
        req1_valid = 0;
        clockModel();
    endtask

    task automatic test_reset_mid_full();
        req0_valid = 1; req0_a = 32'h5; req0_b = 32'h7; rsp_ready = 1;
        clockModel();
        req0_valid = 0; rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_full: got %b expected 1", rsp_valid);
        end
        #2 rst_n = 0;
        resetModel();
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum, req0_ready, req1_ready} !== 38'h0) begin
            errors++; $display("[TB] FAIL midreset_async: got %h expected 0", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum, req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        rst_n = 1; rsp_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL midreset_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
    endtask

    task automatic test_contention();
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL contention_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            clockModel();
            checks++;
            if ({rsp_valid, rsp_id} !== {1'b1, 1'(i % 2)}) begin
                errors++; $display("[TB] FAIL contention_id[%0d]: got %b expected %b", i, {rsp_valid, rsp_id}, {1'b1, 1'(i % 2)});
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== modelRsp()) begin
                errors++; $display("[TB] FAIL contention_rsp[%0d]: got %h expected %h", i, {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, modelRsp());
            end
            if (lastAcc0) begin req0_a = $urandom; req0_b = $urandom; end
            if (lastAcc1) begin req1_a = $urandom; req1_b = $urandom; end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] held;
        held = modelRsp();
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
            end
            clockModel();
            checks++;
            if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== held) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", i, {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, held);
            end
        end
        rsp_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL bp_release: got %b expected 10", {req0_ready, req1_ready});
        end
        clockModel();
        checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== modelRsp()) begin
            errors++; $display("[TB] FAIL bp_after: got %h expected %h", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, modelRsp());
        end
        req0_valid = 0; req1_valid = 0;
        clockModel();
    endtask

    task automatic test_idle_drain();
        int highCount;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        req1_valid = 1; req1_a = a; req1_b = b; rsp_ready = 1;
        clockModel();
        req1_valid = 0;
        highCount = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1'b1) highCount++;
            clockModel();
        end
        checks++;
        if (highCount != 1) begin
            errors++; $display("[TB] FAIL drain_valid_cycles: got %0d expected 1", highCount);
        end
        checks++;
        if ({rsp_valid, rsp_sum} !== {1'b0, a + b}) begin
            errors++; $display("[TB] FAIL drain_sum_hold: got %h expected %h", {rsp_valid, rsp_sum}, {1'b0, a + b});
        end
    endtask

    task automatic test_random();
        logic [W-1:0] corner [4];
        corner[0] = 32'hFFFF_FFFF; corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h0000_0001;
        lastAcc0 = 1; lastAcc1 = 1;
        for (int i = 0; i < 200; i++) begin
            if (!(req0_valid && !lastAcc0)) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            end
            if (!(req1_valid && !lastAcc1)) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            predict();
            checks++;
            if ({req0_ready, req1_ready} !== {exp0, exp1}) begin
                errors++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {exp0, exp1});
            end
            clockModel();
            checks++;
            if ({rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum} !== modelRsp()) begin
                errors++; $display("[TB] FAIL rand_rsp[%0d]: got %h expected %h", i, {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, modelRsp());
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        $display("[TB] starting adder_arbiter bench");
        test_reset();
        test_single();
        test_wrap();
        test_reset_mid_full();
        test_contention();
        test_backpressure();
        test_idle_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
